// File: rtl/at_resp_pkg.sv
// at_resp_pkg: shared definitions for the AT response parser.
// Contents:
//   resp_code_t            - 3-bit classification code reported with each response
//   Cr, Lf                 - line terminator bytes
//   OkStr/ErrorStr/FailStr - response prefixes, right-aligned in 40 bits, with their lengths
//   prefix_miss()          - per-byte prefix compare used to update the match flags
package at_resp_pkg;

    typedef enum logic [2:0] {
        RespNone     = 3'd0,
        RespOk       = 3'd1,
        RespError    = 3'd2,
        RespFail     = 3'd3,
        RespOther    = 3'd4,
        RespOverflow = 3'd5,
        RespTimeout  = 3'd6
    } resp_code_t;

    localparam logic [7:0] Cr = 8'h0D;
    localparam logic [7:0] Lf = 8'h0A;

    // ASCII, first character in the most significant used byte.
    localparam logic [39:0]  OkStr    = 40'h00_0000_4F4B;     // "OK"
    localparam int unsigned  OkLen    = 2;
    localparam logic [39:0]  ErrorStr = 40'h45_5252_4F52;     // "ERROR"
    localparam int unsigned  ErrorLen = 5;
    localparam logic [39:0]  FailStr  = 40'h00_4641_494C;     // "FAIL"
    localparam int unsigned  FailLen  = 4;

    // True when byte b at line index idx contradicts the prefix. Bytes beyond the
    // prefix length never contradict it.
    function automatic logic prefix_miss(input logic [7:0]  b,
                                         input logic [39:0] str,
                                         input int unsigned str_len,
                                         input int unsigned idx);
        logic [39:0] sh;
        if (idx >= str_len) begin
            return 1'b0;
        end
        sh = str >> (8 * (str_len - 1 - idx));
        return sh[7:0] != b;
    endfunction

endpackage

// File: rtl/at_line_buffer.sv
// at_line_buffer: MAX_LINE x 8 register array holding the current response line.
// Ports:
//   clk      - system clock
//   we       - write enable
//   wr_addr  - write index (only written while < MAX_LINE)
//   wr_data  - byte to store
//   rd_addr  - combinational read index
//   rd_data  - buffer[rd_addr], 8'h00 when rd_addr is outside the array
module at_line_buffer #(
    parameter int unsigned MAX_LINE = 32,
    parameter int unsigned LEN_W    = $clog2(MAX_LINE + 1)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LEN_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    localparam int unsigned AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

    logic [7:0] mem_q [MAX_LINE];

    // No reset: contents are only meaningful below the reported length.
    always_ff @(posedge clk) begin
        if (we && (wr_addr < LEN_W'(MAX_LINE))) begin
            mem_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr < LEN_W'(MAX_LINE)) begin
            rd_data = mem_q[rd_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/at_resp_parser.sv
// at_resp_parser: assembles CR/LF-terminated lines from the BLE module's UART stream and
// classifies each as OK / ERROR / FAIL / OTHER, with overflow and optional timeout reports.
// One response is reported per arm.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   arm         - pulse: start (or restart) waiting for a response
//   rx_valid    - qualifies rx_data
//   rx_data     - received byte
//   busy        - armed and no response reported yet
//   resp_valid  - one-cycle report pulse
//   resp_code   - at_resp_pkg::resp_code_t value of the last report
//   resp_len    - stored bytes in the last reported line
//   rd_addr     - read index into the stored line
//   rd_data     - stored byte at rd_addr, 8'h00 when rd_addr >= resp_len
// Build option: define AT_RESP_TIMEOUT_EN to generate the no-response timeout counter.
module at_resp_parser
    import at_resp_pkg::*;
#(
    parameter int unsigned MAX_LINE       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    localparam int unsigned LEN_W         = $clog2(MAX_LINE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             busy,
    output logic             resp_valid,
    output logic [2:0]       resp_code,
    output logic [LEN_W-1:0] resp_len,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    typedef enum logic [1:0] {StIdle, StWait, StCollect, StDrain} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    // Mismatch flags: cleared on arm, set once a byte contradicts the prefix.
    logic             ok_miss_q, ok_miss_d;
    logic             err_miss_q, err_miss_d;
    logic             fail_miss_q, fail_miss_d;
    logic             busy_q, busy_d;
    logic             resp_valid_q, resp_valid_d;
    resp_code_t       resp_code_q, resp_code_d;
    logic [LEN_W-1:0] resp_len_q, resp_len_d;

    logic             is_lf, is_cr, is_data;
    logic             buf_we;
    logic [7:0]       buf_rd_data;
    logic             expire;
    resp_code_t       line_code;

    assign is_lf   = rx_valid && (rx_data == Lf);
    assign is_cr   = rx_valid && (rx_data == Cr);
    assign is_data = rx_valid && !is_lf && !is_cr;

    // Classification of the line collected so far.
    always_comb begin
        line_code = RespOther;
        if ((32'(len_q) >= OkLen) && !ok_miss_q) begin
            line_code = RespOk;
        end else if ((32'(len_q) >= ErrorLen) && !err_miss_q) begin
            line_code = RespError;
        end else if ((32'(len_q) >= FailLen) && !fail_miss_q) begin
            line_code = RespFail;
        end
    end

`ifdef AT_RESP_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (arm) begin
            cnt_d = '0;
        end else if (state_q != StIdle) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the timeout the parser waits indefinitely; TIMEOUT_CYCLES has no effect.
    assign expire = 1'b0;
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        ok_miss_d    = ok_miss_q;
        err_miss_d   = err_miss_q;
        fail_miss_d  = fail_miss_q;
        busy_d       = busy_q;
        resp_valid_d = 1'b0;
        resp_code_d  = resp_code_q;
        resp_len_d   = resp_len_q;
        buf_we       = 1'b0;

        if (arm) begin
            // Arm overrides any byte or expiry in the same cycle.
            state_d     = StWait;
            len_d       = '0;
            ok_miss_d   = 1'b0;
            err_miss_d  = 1'b0;
            fail_miss_d = 1'b0;
            busy_d      = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StWait, StCollect: begin
                    if (is_lf && (state_q == StCollect)) begin
                        state_d      = StIdle;
                        busy_d       = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_code_d  = line_code;
                        resp_len_d   = len_q;
                    end else if (expire) begin
                        state_d      = StIdle;
                        busy_d       = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_code_d  = RespTimeout;
                        resp_len_d   = len_q;
                    end else if (is_data) begin
                        if (len_q < LEN_W'(MAX_LINE)) begin
                            buf_we      = 1'b1;
                            len_d       = len_q + 1'b1;
                            ok_miss_d   = ok_miss_q | prefix_miss(rx_data, OkStr, OkLen,
                                                                  32'(len_q));
                            err_miss_d  = err_miss_q | prefix_miss(rx_data, ErrorStr, ErrorLen,
                                                                   32'(len_q));
                            fail_miss_d = fail_miss_q | prefix_miss(rx_data, FailStr, FailLen,
                                                                    32'(len_q));
                            state_d     = StCollect;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (is_lf) begin
                        state_d      = StIdle;
                        busy_d       = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_code_d  = RespOverflow;
                        resp_len_d   = LEN_W'(MAX_LINE);
                    end else if (expire) begin
                        state_d      = StIdle;
                        busy_d       = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_code_d  = RespTimeout;
                        resp_len_d   = len_q;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            len_q        <= '0;
            ok_miss_q    <= 1'b0;
            err_miss_q   <= 1'b0;
            fail_miss_q  <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= RespNone;
            resp_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            ok_miss_q    <= ok_miss_d;
            err_miss_q   <= err_miss_d;
            fail_miss_q  <= fail_miss_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
            resp_len_q   <= resp_len_d;
        end
    end

    at_line_buffer #(
        .MAX_LINE (MAX_LINE),
        .LEN_W    (LEN_W)
    ) u_line_buffer (
        .clk      (clk),
        .we       (buf_we),
        .wr_addr  (len_q),
        .wr_data  (rx_data),
        .rd_addr  (rd_addr),
        .rd_data  (buf_rd_data)
    );

    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_code  = resp_code_q;
    assign resp_len   = resp_len_q;
    assign rd_data    = (rd_addr < resp_len_q) ? buf_rd_data : 8'h00;

endmodule

// File: tb/tb_at_resp_parser.sv
// Directed bench for at_resp_parser (MAX_LINE=32, TIMEOUT_CYCLES=100).
module tb_at_resp_parser;

    localparam int unsigned MaxLine = 32;
    localparam int unsigned LenW    = $clog2(MaxLine + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            arm = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            busy;
    logic            resp_valid;
    logic [2:0]      resp_code;
    logic [LenW-1:0] resp_len;
    logic [LenW-1:0] rd_addr = '0;
    logic [7:0]      rd_data;

    int n_checks = 0;
    int n_bad    = 0;
    int rpt_cnt  = 0;
    int rpt_base;
    int cyc;

    at_resp_parser #(
        .MAX_LINE       (MaxLine),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .resp_len   (resp_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp_valid) rpt_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_code", 32'(resp_code), 32'd0);
        check_eq("rst_len", 32'(resp_len), 32'd0);
        rst = 1'b0;
        tick();

        // "OK\r\n"
        do_arm();
        check_eq("ok_busy_rise", 32'(busy), 32'd1);
        send_str("OK\r\n");
        check_eq("ok_valid", 32'(resp_valid), 32'd1);
        check_eq("ok_busy_fall", 32'(busy), 32'd0);
        check_eq("ok_code", 32'(resp_code), 32'd1);
        check_eq("ok_len", 32'(resp_len), 32'd2);
        rd_addr = 6'd1; #1;
        check_eq("ok_rd1", 32'(rd_data), 32'h4B);
        rd_addr = 6'd0; #1;
        check_eq("ok_rd0", 32'(rd_data), 32'h4F);
        rd_addr = 6'd2; #1;
        check_eq("ok_rd_past_len", 32'(rd_data), 32'h00);
        // Arm during the report cycle: report stands, parser re-armed.
        do_arm();
        check_eq("ok_pulse_one_cycle", 32'(resp_valid), 32'd0);
        check_eq("rearm_busy", 32'(busy), 32'd1);
        check_eq("ok_code_held", 32'(resp_code), 32'd1);

        // "ERROR:(1D)\r\n" on the arm above
        send_str("ERROR:(1D)\r\n");
        check_eq("err_valid", 32'(resp_valid), 32'd1);
        check_eq("err_code", 32'(resp_code), 32'd2);
        check_eq("err_len", 32'(resp_len), 32'd10);

        // Leading empty line is ignored
        do_arm();
        send_str("\r\nOK+Set:0\r\n");
        check_eq("okset_valid", 32'(resp_valid), 32'd1);
        check_eq("okset_code", 32'(resp_code), 32'd1);
        check_eq("okset_len", 32'(resp_len), 32'd8);

        // Shorter than the ERROR prefix
        do_arm();
        send_str("ERR\r\n");
        check_eq("errshort_code", 32'(resp_code), 32'd4);
        check_eq("errshort_len", 32'(resp_len), 32'd3);

        // Overflow: 40 bytes into a 32-byte line
        do_arm();
        repeat (40) send_byte(8'h41);
        check_eq("ovf_no_early_rpt", 32'(resp_valid), 32'd0);
        send_byte(8'h0A);
        check_eq("ovf_valid", 32'(resp_valid), 32'd1);
        check_eq("ovf_code", 32'(resp_code), 32'd5);
        check_eq("ovf_len", 32'(resp_len), 32'd32);
        rd_addr = 6'd31; #1;
        check_eq("ovf_rd31", 32'(rd_data), 32'h41);
        tick();

        // Bytes while idle are discarded
        rpt_base = rpt_cnt;
        send_str("OK\r\n");
        repeat (3) tick();
        check_eq("idle_no_rpt", 32'(rpt_cnt - rpt_base), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Arm and LF in the same cycle discard the partial line
        do_arm();
        rpt_base = rpt_cnt;
        send_str("AB");
        arm = 1'b1;
        send_byte(8'h0A);
        arm = 1'b0;
        check_eq("armlf_no_valid", 32'(resp_valid), 32'd0);
        check_eq("armlf_busy", 32'(busy), 32'd1);
        send_str("FAIL\r\n");
        tick();
        check_eq("fail_single_rpt", 32'(rpt_cnt - rpt_base), 32'd1);
        check_eq("fail_code", 32'(resp_code), 32'd3);
        check_eq("fail_len", 32'(resp_len), 32'd4);

        // Timeout after "O" only
        do_arm();
        cyc = 0;
        rpt_base = rpt_cnt;
        send_byte(8'h4F);
        cyc = 1;
`ifdef AT_RESP_TIMEOUT_EN
        while (!resp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check_eq("to_latency", 32'(cyc), 32'd100);
        check_eq("to_code", 32'(resp_code), 32'd6);
        check_eq("to_len", 32'(resp_len), 32'd1);
        check_eq("to_busy", 32'(busy), 32'd0);
`else
        repeat (10000) tick();
        check_eq("noto_no_rpt", 32'(rpt_cnt - rpt_base), 32'd0);
        check_eq("noto_busy", 32'(busy), 32'd1);
`endif

        // Reset mid-line
        do_arm();
        send_str("OK");
        rst = 1'b1;
        #1;
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        check_eq("rstmid_code", 32'(resp_code), 32'd0);
        check_eq("rstmid_valid", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b0;
        rpt_base = rpt_cnt;
        send_str("\r\n");
        repeat (2) tick();
        check_eq("rstmid_no_rpt", 32'(rpt_cnt - rpt_base), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/at_resp_parser.md
# at_resp_parser

Receive-side companion to the AT command memory: consumes the byte stream arriving from the HM-10/HC-05 module's UART TX, assembles CR/LF-terminated response lines and classifies each as OK, ERROR, FAIL or OTHER, with a no-response timeout. Sits between the UART receiver and the BLE configuration sequencer. The sequencer arms the parser after sending each command and waits for exactly one classified response.

## Interface
- `MAX_LINE`, 32: line buffer depth in bytes, excluding CR/LF.
- `TIMEOUT_CYCLES`, 50_000_000: cycles allowed from arm to the terminating LF.
- `LEN_W`, `$clog2(MAX_LINE+1)`: derived; not to be overridden.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `arm` in 1: one-cycle pulse that starts or restarts waiting for a response.
- `rx_valid` in 1: qualifies `rx_data`; at most one byte per cycle.
- `rx_data` in 8: received byte.
- `busy` out 1: armed and no response reported yet.
- `resp_valid` out 1: one-cycle pulse; the response fields are valid.
- `resp_code` out 3: 0 NONE, 1 OK, 2 ERROR, 3 FAIL, 4 OTHER, 5 OVERFLOW, 6 TIMEOUT.
- `resp_len` out LEN_W: number of stored bytes in the reported line; held until the next report.
- `rd_addr` in LEN_W: read index into the stored line.
- `rd_data` out 8: combinational read of `buffer[rd_addr]`; 8'h00 if `rd_addr >= resp_len`.

## Operation
- States:
  - IDLE: not armed; all bytes are discarded.
  - WAIT: armed, current line is empty.
  - COLLECT: storing bytes.
  - DRAIN: overflowed; discarding bytes until LF.
- Transitions:
  - `arm` from any state: go to WAIT; clear the length and match flags; reload the timeout.
  - In WAIT, LF or CR: ignored; empty lines are not reported.
  - In WAIT, any other byte: store it and go to COLLECT.
  - In COLLECT, CR: dropped.
  - In COLLECT, LF: report, then go to IDLE.
  - In COLLECT, any other byte with length < MAX_LINE: store it.
  - In COLLECT, any other byte with length = MAX_LINE: go to DRAIN.
  - In DRAIN, LF: report OVERFLOW with `resp_len` = MAX_LINE, then go to IDLE.
- Classification uses prefix match flags updated per byte at index `len`; there is no post-LF compare pass.
  - Line begins "OK" → OK (covers "OK", "OK+Set:0").
  - Line begins "ERROR" → ERROR (covers "ERROR:(1D)").
  - Line begins "FAIL" → FAIL.
  - Any other non-empty line → OTHER.
  - A line shorter than a prefix does not match that prefix ("ERR" → OTHER).
- One response is reported per arm. Bytes arriving after the report are discarded until the next `arm`.
- Buffer contents are valid only while no new line is being collected. The sequencer must read before re-arming.

## Timing
- Reset values: state IDLE, `busy` 0, `resp_valid` 0, `resp_code` 0, `resp_len` 0, buffer contents don't-care, timeout counter 0.
- `busy` rises the cycle after `arm`. It falls in the same cycle that `resp_valid` is asserted.
- Latency: `resp_valid` is asserted the cycle after the LF is accepted.
- Timeout: the counter runs in WAIT, COLLECT and DRAIN. When the count reaches TIMEOUT_CYCLES-1, the next cycle reports TIMEOUT with `resp_len` = bytes stored so far.
- LF and timeout expiry in the same cycle: LF wins.
- `arm` and LF in the same cycle: `arm` wins; the line is discarded with no report.
- `arm` in the same cycle as `resp_valid`: the report stands and the parser re-enters WAIT.
- Reset mid-line: immediate return to IDLE with no report.

## Configuration
- `AT_RESP_TIMEOUT_EN` defined: timeout counter present; TIMEOUT is reported as described above.
- Not defined: no counter logic is generated; the parser waits indefinitely; code 6 is never produced; `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `at_resp_pkg`, alongside `cmd_mem_pkg`, holds:
  - `resp_code_t` enum (3-bit).
  - Prefix byte constants "OK", "ERROR", "FAIL" with their lengths.
  - CR (8'h0D) and LF (8'h0A) constants.
- One sub-module: `at_line_buffer`, a MAX_LINE×8 register array with write port and combinational read port.
- FSM, match flags and timeout counter live in the top module.

## Test plan
- Arm, feed "OK\r\n" → `resp_valid` one cycle after LF, code 1, `resp_len` 2, `rd_addr`=1 gives 8'h4B.
- Arm, feed "ERROR:(1D)\r\n" → code 2, `resp_len` 10. Separately, "\r\nOK+Set:0\r\n" → leading empty line ignored, code 1, `resp_len` 8.
- Arm, feed "ERR\r\n" → code 4. Separately, feed 40 'A' bytes then LF with MAX_LINE=32 → code 5, `resp_len` 32.
- With `AT_RESP_TIMEOUT_EN` and TIMEOUT_CYCLES=100, arm and send "O" only:
  - code 6 reported 100 cycles after `arm`, `resp_len` 1.
  - Repeat without the macro: no report after 10 000 cycles, `busy` stays 1.
- Bytes "OK\r\n" sent while IDLE → no report.
- Arm and LF asserted in the same cycle mid-line, then "FAIL\r\n" → a single report, code 3.
- Assert `rst` mid-line → `busy` 0 and `resp_code` 0 in the same cycle; no `resp_valid`.
